// File: rtl/mem_lsu.sv
// Memory-access stage: runs loads/stores on a req/ack data-RAM port, passes other ops through,
// and delivers a registered result bundle to write-back.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] inst_pc_i,
    input  logic [1:0]  excepttype_i,
    input  logic        flush_i,
    output logic        dreq_o,
    output logic        dwe_o,
    output logic [31:0] daddr_o,
    output logic [3:0]  dwstrb_o,
    output logic [31:0] dwdata_o,
    input  logic        dack_i,
    input  logic [31:0] drdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] inst_pc_o,
    output logic [1:0]  excepttype_o,
    output logic        stallreq_o
);

    localparam logic [7:0] ExeLdBOp  = 8'h20;
    localparam logic [7:0] ExeLdHOp  = 8'h21;
    localparam logic [7:0] ExeLdWOp  = 8'h22;
    localparam logic [7:0] ExeLdBuOp = 8'h23;
    localparam logic [7:0] ExeLdHuOp = 8'h24;
    localparam logic [7:0] ExeStBOp  = 8'h28;
    localparam logic [7:0] ExeStHOp  = 8'h29;
    localparam logic [7:0] ExeStWOp  = 8'h2A;
    localparam logic [1:0] ExcAle    = 2'b11;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e      state_q, state_d;
    logic        killed_q, killed_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  tag_wd_q, tag_wd_d;
    logic        tag_wreg_q, tag_wreg_d;
    logic [31:0] tag_pc_q, tag_pc_d;

    logic        dreq_d, dwe_d, wb_valid_d, wreg_d;
    logic [31:0] daddr_d, dwdata_d, wdata_d, inst_pc_d;
    logic [3:0]  dwstrb_d;
    logic [4:0]  wd_d;
    logic [1:0]  excepttype_d;

    logic        is_load, is_store, is_half, is_word, misaligned, mem_issue;
    logic [31:0] rd_shifted, load_data;

    assign is_load    = (aluop_i == ExeLdBOp) || (aluop_i == ExeLdHOp) || (aluop_i == ExeLdWOp) ||
                        (aluop_i == ExeLdBuOp) || (aluop_i == ExeLdHuOp);
    assign is_store   = (aluop_i == ExeStBOp) || (aluop_i == ExeStHOp) || (aluop_i == ExeStWOp);
    assign is_half    = (aluop_i == ExeLdHOp) || (aluop_i == ExeLdHuOp) || (aluop_i == ExeStHOp);
    assign is_word    = (aluop_i == ExeLdWOp) || (aluop_i == ExeStWOp);
    assign misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
    assign mem_issue  = ex_valid_i && (is_load || is_store) && !misaligned &&
                        (excepttype_i == 2'b00) && !flush_i;

    // Gated by reset so the stall drops the moment the transaction is abandoned.
    assign stallreq_o = rst && (((state_q == StIdle) && mem_issue) ||
                                ((state_q == StReq) && !dack_i));

    assign rd_shifted = drdata_i >> {off_q, 3'b000};

    always_comb begin
        load_data = rd_shifted;
        case (op_q)
            ExeLdBOp:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            ExeLdBuOp: load_data = {24'h0, rd_shifted[7:0]};
            ExeLdHOp:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            ExeLdHuOp: load_data = {16'h0, rd_shifted[15:0]};
            default:   load_data = rd_shifted;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        killed_d   = killed_q;
        op_d       = op_q;
        off_d      = off_q;
        tag_wd_d   = tag_wd_q;
        tag_wreg_d = tag_wreg_q;
        tag_pc_d   = tag_pc_q;
        unique case (state_q)
            StIdle: begin
                if (mem_issue) begin
                    state_d    = StReq;
                    killed_d   = 1'b0;
                    op_d       = aluop_i;
                    off_d      = mem_addr_i[1:0];
                    tag_wd_d   = wd_i;
                    tag_wreg_d = wreg_i;
                    tag_pc_d   = inst_pc_i;
                end
            end
            StReq: begin
                if (flush_i) killed_d = 1'b1;
                if (dack_i) begin
                    state_d  = StIdle;
                    killed_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered-output next values.
    always_comb begin
        dreq_d       = dreq_o;
        dwe_d        = dwe_o;
        daddr_d      = daddr_o;
        dwstrb_d     = dwstrb_o;
        dwdata_d     = dwdata_o;
        wb_valid_d   = 1'b0;
        wd_d         = wd_o;
        wreg_d       = wreg_o;
        wdata_d      = wdata_o;
        inst_pc_d    = inst_pc_o;
        excepttype_d = excepttype_o;
        unique case (state_q)
            StIdle: begin
                if (mem_issue) begin
                    dreq_d  = 1'b1;
                    dwe_d   = is_store;
                    daddr_d = {mem_addr_i[31:2], 2'b00};
                    case (aluop_i)
                        ExeStBOp: begin
                            dwstrb_d = 4'b0001 << mem_addr_i[1:0];
                            dwdata_d = {4{reg2_i[7:0]}};
                        end
                        ExeStHOp: begin
                            dwstrb_d = 4'b0011 << {mem_addr_i[1], 1'b0};
                            dwdata_d = {2{reg2_i[15:0]}};
                        end
                        ExeStWOp: begin
                            dwstrb_d = 4'b1111;
                            dwdata_d = reg2_i;
                        end
                        default: begin
                            dwstrb_d = 4'b0000;
                            dwdata_d = reg2_i;
                        end
                    endcase
                end else if (ex_valid_i && !flush_i) begin
                    wb_valid_d = 1'b1;
                    wd_d       = wd_i;
                    wdata_d    = wdata_i;
                    inst_pc_d  = inst_pc_i;
                    if (excepttype_i != 2'b00) begin
                        excepttype_d = excepttype_i;
                        wreg_d       = 1'b0;
                    end else if (misaligned) begin
                        excepttype_d = ExcAle;
                        wreg_d       = 1'b0;
                    end else begin
                        excepttype_d = 2'b00;
                        wreg_d       = wreg_i;
                    end
                end
            end
            StReq: begin
                if (dack_i) begin
                    dreq_d       = 1'b0;
                    wb_valid_d   = !(killed_q || flush_i);
                    wd_d         = tag_wd_q;
                    inst_pc_d    = tag_pc_q;
                    excepttype_d = 2'b00;
                    if ((op_q == ExeStBOp) || (op_q == ExeStHOp) || (op_q == ExeStWOp)) begin
                        wreg_d  = 1'b0;
                        wdata_d = 32'h0;
                    end else begin
                        wreg_d  = tag_wreg_q;
                        wdata_d = load_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            killed_q     <= 1'b0;
            op_q         <= 8'h0;
            off_q        <= 2'b00;
            tag_wd_q     <= 5'h0;
            tag_wreg_q   <= 1'b0;
            tag_pc_q     <= 32'h0;
            dreq_o       <= 1'b0;
            dwe_o        <= 1'b0;
            daddr_o      <= 32'h0;
            dwstrb_o     <= 4'h0;
            dwdata_o     <= 32'h0;
            wb_valid_o   <= 1'b0;
            wd_o         <= 5'h0;
            wreg_o       <= 1'b0;
            wdata_o      <= 32'h0;
            inst_pc_o    <= 32'h0;
            excepttype_o <= 2'b00;
        end else begin
            state_q      <= state_d;
            killed_q     <= killed_d;
            op_q         <= op_d;
            off_q        <= off_d;
            tag_wd_q     <= tag_wd_d;
            tag_wreg_q   <= tag_wreg_d;
            tag_pc_q     <= tag_pc_d;
            dreq_o       <= dreq_d;
            dwe_o        <= dwe_d;
            daddr_o      <= daddr_d;
            dwstrb_o     <= dwstrb_d;
            dwdata_o     <= dwdata_d;
            wb_valid_o   <= wb_valid_d;
            wd_o         <= wd_d;
            wreg_o       <= wreg_d;
            wdata_o      <= wdata_d;
            inst_pc_o    <= inst_pc_d;
            excepttype_o <= excepttype_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu against a byte-level behavioural model.
module tb_mem_lsu;

    localparam logic [7:0] LdB  = 8'h20;
    localparam logic [7:0] LdH  = 8'h21;
    localparam logic [7:0] LdW  = 8'h22;
    localparam logic [7:0] LdBu = 8'h23;
    localparam logic [7:0] LdHu = 8'h24;
    localparam logic [7:0] StB  = 8'h28;
    localparam logic [7:0] StH  = 8'h29;
    localparam logic [7:0] StW  = 8'h2A;
    localparam logic [7:0] AluOp = 8'h11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [7:0]  aluop_i = '0;
    logic [31:0] mem_addr_i = '0, reg2_i = '0, wdata_i = '0, inst_pc_i = '0, drdata_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0, flush_i = 1'b0, dack_i = 1'b0;
    logic [1:0]  excepttype_i = '0;
    logic        dreq_o, dwe_o, wb_valid_o, wreg_o, stallreq_o;
    logic [31:0] daddr_o, dwdata_o, wdata_o, inst_pc_o;
    logic [3:0]  dwstrb_o;
    logic [4:0]  wd_o;
    logic [1:0]  excepttype_o;

    int n_checks = 0;
    int n_fail = 0;
    int stall_cycles;
    logic [7:0] mem_ops [8] = '{LdB, LdH, LdW, LdBu, LdHu, StB, StH, StW};
    logic [7:0] alu_ops [3] = '{8'h00, 8'h0A, AluOp};

    always #5 clk = ~clk;

    mem_lsu u_dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid_i   (ex_valid_i),
        .aluop_i      (aluop_i),
        .mem_addr_i   (mem_addr_i),
        .reg2_i       (reg2_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .inst_pc_i    (inst_pc_i),
        .excepttype_i (excepttype_i),
        .flush_i      (flush_i),
        .dreq_o       (dreq_o),
        .dwe_o        (dwe_o),
        .daddr_o      (daddr_o),
        .dwstrb_o     (dwstrb_o),
        .dwdata_o     (dwdata_o),
        .dack_i       (dack_i),
        .drdata_i     (drdata_i),
        .wb_valid_o   (wb_valid_o),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .inst_pc_o    (inst_pc_o),
        .excepttype_o (excepttype_o),
        .stallreq_o   (stallreq_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_size(input logic [7:0] op);
        if (op == LdB || op == LdBu || op == StB) return 1;
        if (op == LdH || op == LdHu || op == StH) return 2;
        if (op == LdW || op == StW) return 4;
        return 0;
    endfunction

    function automatic bit is_st(input logic [7:0] op);
        return op == StB || op == StH || op == StW;
    endfunction

    // Byte lanes [off, off+size) are written.
    function automatic logic [3:0] exp_strb(input int sz, input int off);
        logic [3:0] s = '0;
        for (int b = 0; b < 4; b++) s[b] = (b >= off) && (b < off + sz);
        return s;
    endfunction

    // Each lane carries the store byte that would land there for any aligned offset.
    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] r2);
        logic [31:0] v = '0;
        for (int b = 0; b < 4; b++) v |= ((r2 >> (8 * (b % sz))) & 32'hFF) << (8 * b);
        return v;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input int off,
                                             input logic [31:0] rd);
        int sz = op_size(op);
        logic [31:0] v = '0;
        for (int b = 0; b < sz; b++) v |= ((rd >> (8 * (off + b))) & 32'hFF) << (8 * b);
        if ((op == LdB || op == LdH) && v[8 * sz - 1] && sz < 4) v |= 32'hFFFF_FFFF << (8 * sz);
        return v;
    endfunction

    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                          input logic [31:0] wdat, input logic [31:0] pc, input logic [4:0] wd,
                          input logic wreg, input logic [1:0] exc, input int k,
                          input bit fl_idle, input bit fl_req, input logic [31:0] rdata);
        int sz = op_size(op);
        int off = int'(addr[1:0]);
        bit st = is_st(op);
        bit mem = (sz != 0);
        bit mis = mem && ((addr % sz) != 0);
        bit go = mem && (exc == 2'b00) && !mis && !fl_idle;
        ex_valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = r2; wdata_i = wdat;
        inst_pc_i = pc; wd_i = wd; wreg_i = wreg; excepttype_i = exc; flush_i = fl_idle;
        dack_i = 1'b0;
        #1;
        stall_cycles = stallreq_o ? 1 : 0;
        check_eq("stall_issue", stallreq_o, go);
        tick();
        flush_i = 1'b0;
        if (!go) begin
            check_eq("dreq_none", dreq_o, 0);
            check_eq("wbv_direct", wb_valid_o, !fl_idle);
            if (!fl_idle) begin
                check_eq("exc_direct", excepttype_o,
                         (exc != 2'b00) ? exc : (mis ? 2'b11 : 2'b00));
                check_eq("wreg_direct", wreg_o, (exc != 2'b00 || mis) ? 1'b0 : wreg);
                check_eq("wd_direct", wd_o, wd);
                check_eq("pc_direct", inst_pc_o, pc);
                if (!mem && exc == 2'b00) check_eq("wdata_alu", wdata_o, wdat);
            end
        end else begin
            check_eq("dreq_issue", dreq_o, 1);
            check_eq("daddr", daddr_o, addr & 32'hFFFF_FFFC);
            check_eq("dwe", dwe_o, st);
            check_eq("dwstrb", dwstrb_o, st ? exp_strb(sz, off) : 4'b0000);
            if (st) check_eq("dwdata", dwdata_o, exp_wdata(sz, r2));
            check_eq("wbv_req", wb_valid_o, 0);
            for (int j = 1; j <= k; j++) begin
                flush_i = fl_req && (j == 1);
                dack_i = (j == k);
                drdata_i = (j == k) ? rdata : $urandom;
                #1;
                if (stallreq_o) stall_cycles++;
                check_eq("stall_req", stallreq_o, j != k);
                tick();
                flush_i = 1'b0;
                dack_i = 1'b0;
                if (j < k) begin
                    check_eq("dreq_hold", dreq_o, 1);
                    check_eq("daddr_hold", daddr_o, addr & 32'hFFFF_FFFC);
                    check_eq("wbv_wait", wb_valid_o, 0);
                end
            end
            check_eq("dreq_done", dreq_o, 0);
            check_eq("wbv_retire", wb_valid_o, !fl_req);
            if (!fl_req) begin
                check_eq("wreg_mem", wreg_o, st ? 1'b0 : wreg);
                check_eq("wdata_mem", wdata_o, st ? 32'h0 : exp_load(op, off, rdata));
                check_eq("wd_mem", wd_o, wd);
                check_eq("pc_mem", inst_pc_o, pc);
                check_eq("exc_mem", excepttype_o, 0);
            end
        end
        // Idle cycle with a stray ack that must be ignored.
        ex_valid_i = 1'b0;
        dack_i = 1'($urandom_range(0, 1));
        drdata_i = $urandom;
        tick();
        check_eq("wbv_pulse", wb_valid_o, 0);
        check_eq("dreq_idle", dreq_o, 0);
        dack_i = 1'b0;
    endtask

    initial begin
        #3;
        check_eq("rst_dreq", dreq_o, 0);
        check_eq("rst_wbv", wb_valid_o, 0);
        check_eq("rst_wdata", wdata_o, 0);
        check_eq("rst_daddr", daddr_o, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        run_op(AluOp, 32'h0, 32'h0, 32'h1234_5678, 32'h100, 5'd5, 1'b1, 2'b00, 1, 0, 0, 32'h0);
        run_op(LdB, 32'h1003, 32'h0, 32'h0, 32'h104, 5'd7, 1'b1, 2'b00, 4, 0, 0, 32'h80AA_BBCC);
        check_eq("ldb_stall_cycles", stall_cycles, 4);
        run_op(LdBu, 32'h1003, 32'h0, 32'h0, 32'h108, 5'd8, 1'b1, 2'b00, 2, 0, 0, 32'h80AA_BBCC);
        run_op(StH, 32'h2002, 32'hDEAD_BEEF, 32'h0, 32'h10C, 5'd9, 1'b1, 2'b00, 1, 0, 0, 32'h0);
        run_op(LdW, 32'h3001, 32'h0, 32'h0, 32'h110, 5'd3, 1'b1, 2'b00, 1, 0, 0, 32'h0);
        run_op(LdW, 32'h3000, 32'h0, 32'h0, 32'h114, 5'd4, 1'b1, 2'b00, 3, 0, 1, 32'h5555_AAAA);
        check_eq("flush_stall_cycles", stall_cycles, 3);

        // Abandon a transaction with an asynchronous reset.
        ex_valid_i = 1'b1; aluop_i = LdW; mem_addr_i = 32'h5000; excepttype_i = 2'b00;
        tick();
        check_eq("pre_rst_dreq", dreq_o, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_dreq", dreq_o, 0);
        check_eq("arst_daddr", daddr_o, 0);
        check_eq("arst_wdata", wdata_o, 0);
        check_eq("arst_pc", inst_pc_o, 0);
        check_eq("arst_wd", wd_o, 0);
        check_eq("arst_stall", stallreq_o, 0);
        ex_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("post_rst_dreq", dreq_o, 0);
        run_op(StW, 32'h4000, 32'hCAFE_F00D, 32'h0, 32'h118, 5'd1, 1'b0, 2'b00, 2, 0, 0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            logic [7:0]  op;
            logic [31:0] addr;
            logic [1:0]  exc;
            int          r;
            r = $urandom_range(0, 9);
            op = (r < 2) ? alu_ops[$urandom_range(0, 2)] : mem_ops[r - 2];
            addr = $urandom;
            if (op_size(op) > 1 && $urandom_range(0, 3) != 0)
                addr = addr & ~(32'(op_size(op)) - 32'd1);
            exc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_op(op, addr, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   exc, $urandom_range(1, 4), $urandom_range(0, 15) == 0,
                   $urandom_range(0, 7) == 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
